// File: rtl/matrix_product_accumulator_pkg.sv
// Shared constants and width helpers for the matrix product accumulator.
package matrix_product_accumulator_pkg;

    // Product width coming out of the 4x4 unsigned multiplier.
    localparam int unsigned ProdWidth = 8;

    // Default matrix dimension.
    localparam int unsigned DefaultN = 2;

    // Width of an index counter; a 1x1 matrix still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Accumulator width: N products of ProdWidth bits can never overflow it.
    function automatic int unsigned acc_width(input int unsigned n);
        return ProdWidth + $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_product_accumulator_index_counter.sv
// Nested k/j/i wrap counter walking the product stream in i-outer, j-middle, k-inner order.
module matrix_product_accumulator_index_counter
    import matrix_product_accumulator_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            advance_i,
    input  logic            clr_i,
    output logic [IdxW-1:0] k_o,
    output logic [IdxW-1:0] j_o,
    output logic [IdxW-1:0] i_o,
    output logic            k_last_o,
    output logic            elem_last_o
);

    localparam logic [IdxW-1:0] IdxMax = IdxW'(N - 1);

    logic [IdxW-1:0] k_q, k_d;
    logic [IdxW-1:0] j_q, j_d;
    logic [IdxW-1:0] i_q, i_d;

    // Next-state: k steps every advance, j on k wrap, i on j wrap.
    always_comb begin
        k_d = k_q;
        j_d = j_q;
        i_d = i_q;
        if (clr_i) begin
            k_d = '0;
            j_d = '0;
            i_d = '0;
        end else if (advance_i) begin
            if (k_q == IdxMax) begin
                k_d = '0;
                if (j_q == IdxMax) begin
                    j_d = '0;
                    i_d = (i_q == IdxMax) ? '0 : i_q + 1'b1;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end else begin
                k_d = k_q + 1'b1;
            end
        end
    end

    // Index state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_q <= '0;
            j_q <= '0;
            i_q <= '0;
        end else begin
            k_q <= k_d;
            j_q <= j_d;
            i_q <= i_d;
        end
    end

    assign k_o         = k_q;
    assign j_o         = j_q;
    assign i_o         = i_q;
    assign k_last_o    = (k_q == IdxMax);
    assign elem_last_o = (i_q == IdxMax) && (j_q == IdxMax);

endmodule

// File: rtl/matrix_product_accumulator.sv
// Sums N consecutive element products into one C[i][j] and hands it out over valid/ready.
module matrix_product_accumulator
    import matrix_product_accumulator_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned PROD_W = ProdWidth,
    localparam int unsigned AccW = acc_width(N),
    localparam int unsigned IdxW = idx_width(N)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PROD_W-1:0] in_prod_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [AccW-1:0]   out_data_o,
    output logic [IdxW-1:0]   out_row_o,
    output logic [IdxW-1:0]   out_col_o,
    output logic              out_last_o,
    output logic              busy_o
);

    logic [IdxW-1:0] k, j, i;
    logic            k_last, elem_last;
    logic            accept;
    logic [AccW-1:0] prod_ext;

    logic [AccW-1:0] acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [AccW-1:0] out_data_q, out_data_d;
    logic [IdxW-1:0] out_row_q, out_row_d;
    logic [IdxW-1:0] out_col_q, out_col_d;
    logic            out_last_q, out_last_d;

    // Stall the input whenever a held element cannot leave, even if this product would not
    // complete one; keeps the control a single combinational term.
    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign prod_ext   = AccW'(in_prod_i);

    matrix_product_accumulator_index_counter #(
        .N(N)
    ) u_index_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .advance_i   (accept && !clr_i),
        .clr_i       (clr_i),
        .k_o         (k),
        .j_o         (j),
        .i_o         (i),
        .k_last_o    (k_last),
        .elem_last_o (elem_last)
    );

    // Next-state for accumulator and output slot; a completion overrides a same-cycle drain.
    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_last_d  = out_last_q;
        if (clr_i) begin
            acc_d       = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_row_d   = '0;
            out_col_d   = '0;
            out_last_d  = 1'b0;
        end else begin
            if (out_valid_q && out_ready_i) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (k_last) begin
                    out_data_d  = acc_q + prod_ext;
                    out_row_d   = i;
                    out_col_d   = j;
                    out_last_d  = elem_last;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = (k == '0) ? prod_ext : acc_q + prod_ext;
                end
            end
        end
    end

    // Accumulator and output slot registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_row_o   = out_row_q;
    assign out_col_o   = out_col_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = (k != '0) || (j != '0) || (i != '0);

endmodule

// File: tb/tb_matrix_product_accumulator.sv
// Randomized bench for matrix_product_accumulator against a matrix-level reference model.
module tb_matrix_product_accumulator;
    import matrix_product_accumulator_pkg::*;

    localparam int unsigned N      = 2;
    localparam int unsigned AccW   = acc_width(N);
    localparam int unsigned IdxW   = idx_width(N);
    localparam int          MaxMat = 8;
    localparam int          Budget = 4000;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            clr_i = 1'b0;
    logic            in_valid_i = 1'b0;
    logic            in_ready_o;
    logic [7:0]      in_prod_i = '0;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;
    logic [AccW-1:0] out_data_o;
    logic [IdxW-1:0] out_row_o;
    logic [IdxW-1:0] out_col_o;
    logic            out_last_o;
    logic            busy_o;

    matrix_product_accumulator #(
        .N(N)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_prod_i   (in_prod_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_row_o   (out_row_o),
        .out_col_o   (out_col_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference matrices, one pair per matrix in the current stream.
    int a_m [MaxMat][N][N];
    int b_m [MaxMat][N][N];

    int n_checks = 0;
    int n_pass   = 0;
    int accepted = 0;
    int drained  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Product number p in the stream: i outer, j middle, k inner, matrix by matrix.
    function automatic int prod_at(input int p);
        int m, r, i, j, k;
        m = p / (N * N * N);
        r = p % (N * N * N);
        i = r / (N * N);
        j = (r / N) % N;
        k = r % N;
        return a_m[m][i][k] * b_m[m][k][j];
    endfunction

    // Element e of the result stream as a plain dot product.
    function automatic int elem_at(input int e);
        int m, pos, s;
        m   = e / (N * N);
        pos = e % (N * N);
        s   = 0;
        for (int k = 0; k < N; k++) s += a_m[m][pos / N][k] * b_m[m][k][pos % N];
        return s;
    endfunction

    task automatic load_basic(input int m);
        a_m[m][0][0] = 1; a_m[m][0][1] = 2; a_m[m][1][0] = 3; a_m[m][1][1] = 4;
        b_m[m][0][0] = 5; b_m[m][0][1] = 6; b_m[m][1][0] = 7; b_m[m][1][1] = 8;
    endtask

    task automatic load_const(input int m, input int v);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[m][i][j] = v;
                b_m[m][i][j] = v;
            end
    endtask

    task automatic load_random(input int m);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                a_m[m][i][j] = int'($urandom_range(0, 15));
                b_m[m][i][j] = int'($urandom_range(0, 15));
            end
    endtask

    // One cycle: drive at negedge, check at negedge+1, advance the model for the coming edge.
    // vmode 0: valid always, 1: random. rmode 0: ready high, 1: random, 2: toggling.
    task automatic step(input int total, input int vmode, input int rmode, input int cyc);
        int  completed;
        bit  exp_valid;
        int  pos;
        @(negedge clk_i);
        in_valid_i = (accepted < total) && (vmode == 0 || $urandom_range(0, 3) != 0);
        in_prod_i  = (accepted < total) ? 8'(prod_at(accepted)) : 8'd0;
        case (rmode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'(cyc & 1);
        endcase
        #1;
        completed = accepted / N;
        exp_valid = completed > drained;
        check("out_valid", 32'(out_valid_o), 32'(exp_valid));
        check("in_ready", 32'(in_ready_o), 32'(!exp_valid || out_ready_i));
        check("busy", 32'(busy_o), 32'((accepted % (N * N * N)) != 0));
        if (exp_valid) begin
            pos = drained % (N * N);
            check("out_data", 32'(out_data_o), 32'(elem_at(drained)));
            check("out_row", 32'(out_row_o), 32'(pos / N));
            check("out_col", 32'(out_col_o), 32'(pos % N));
            check("out_last", 32'(out_last_o), 32'(pos == N * N - 1));
        end
        if (in_valid_i && (!exp_valid || out_ready_i)) accepted++;
        if (exp_valid && out_ready_i) drained++;
    endtask

    task automatic run_phase(input int nmat, input int vmode, input int rmode);
        int total, elems, cyc;
        accepted = 0;
        drained  = 0;
        total    = nmat * N * N * N;
        elems    = nmat * N * N;
        cyc      = 0;
        while (drained < elems && cyc < Budget) begin
            step(total, vmode, rmode, cyc);
            cyc++;
        end
        if (drained < elems) check("phase_timeout", 32'(drained), 32'(elems));
        // Idle cycle: slot must be empty and busy low after the last element.
        step(total, 0, 0, cyc);
    endtask

    initial begin
        #2;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_data", 32'(out_data_o), 32'd0);
        check("rst_out_row", 32'(out_row_o), 32'd0);
        check("rst_out_col", 32'(out_col_o), 32'd0);
        check("rst_out_last", 32'(out_last_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic 2x2 back-to-back, then max values.
        load_basic(0);
        run_phase(1, 0, 0);
        load_const(0, 15);
        run_phase(1, 0, 0);

        // Random matrices under random valid and ready, then toggling ready.
        for (int m = 0; m < MaxMat; m++) load_random(m);
        run_phase(MaxMat, 1, 1);
        load_basic(0);
        for (int m = 1; m < 4; m++) load_random(m);
        run_phase(4, 0, 2);
        for (int m = 0; m < MaxMat; m++) load_random(m);
        run_phase(MaxMat, 0, 1);

        // Reset after three products: outputs clear without waiting for a clock.
        @(negedge clk_i);
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_prod_i   = 8'd5;
        @(negedge clk_i);
        in_prod_i = 8'd14;
        @(negedge clk_i);
        in_prod_i = 8'd6;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid_o), 32'd0);
        check("arst_out_data", 32'(out_data_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        load_basic(0);
        run_phase(1, 0, 0);

        // clr with an element held; the product presented alongside clr must be dropped.
        @(negedge clk_i);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_prod_i   = 8'd5;
        @(negedge clk_i);
        in_prod_i = 8'd14;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        check("held_valid", 32'(out_valid_o), 32'd1);
        check("held_data", 32'(out_data_o), 32'd19);
        check("held_in_ready", 32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        check("held_stable", 32'(out_data_o), 32'd19);
        clr_i       = 1'b1;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_prod_i   = 8'd6;
        @(negedge clk_i);
        clr_i      = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("clr_out_valid", 32'(out_valid_o), 32'd0);
        check("clr_busy", 32'(busy_o), 32'd0);
        load_basic(0);
        run_phase(1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
